// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit: EX/MEM controls to req/ready/rvalid data-memory access
// Aligns store lanes, extracts and extends load data, stalls while an access is outstanding.
module mem_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] alu_data_M,
  input  logic [31:0] store_data_M,
  input  logic [2:0]  lsu_op_M,
  input  logic        mem_rd_M,
  input  logic        mem_wr_M,
  output logic [31:0] read_data_M,
  output logic        stall_M,
  output logic        err_M,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] cap;
  logic [2:0]  op_q;
  logic [1:0]  a_q;
  logic        ld_q;
  logic        err_q;

  logic        acc, bad, op_ok, misal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign acc = mem_rd_M | mem_wr_M;

  always_comb begin
    op_ok = 1'b0;
    case (lsu_op_M)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
  end

  assign misal = ((lsu_op_M[1:0] == 2'b01) && alu_data_M[0]) ||
                 ((lsu_op_M[1:0] == 2'b10) && (alu_data_M[1:0] != 2'b00));
  assign bad   = !op_ok || misal || (mem_rd_M && mem_wr_M);

  // Store data is replicated across lanes; the byte enables select the lanes that land.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = store_data_M;
    case (lsu_op_M[1:0])
      2'b00: begin
        st_be    = 4'b0001 << alu_data_M[1:0];
        st_wdata = {4{store_data_M[7:0]}};
      end
      2'b01: begin
        st_be    = alu_data_M[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data_M[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = store_data_M;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cap          <= '0;
      op_q         <= '0;
      a_q          <= '0;
      ld_q         <= 1'b0;
      err_q        <= 1'b0;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc && !bad) begin
            state        <= REQ;
            cnt          <= '0;
            cap          <= '0;
            err_q        <= 1'b0;
            op_q         <= lsu_op_M;
            a_q          <= alu_data_M[1:0];
            ld_q         <= mem_rd_M;
            o_dmem_req   <= 1'b1;
            o_dmem_we    <= mem_wr_M;
            o_dmem_addr  <= {alu_data_M[31:2], 2'b00};
            o_dmem_wdata <= mem_wr_M ? st_wdata : 32'd0;
            o_dmem_be    <= mem_wr_M ? st_be : 4'b0000;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          // Acceptance wins over timeout so a handshake that completes is never lost.
          if (i_dmem_ready || (cnt >= CW'(TIMEOUT - 1))) begin
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_wdata <= '0;
            o_dmem_be    <= '0;
            if (i_dmem_ready) begin
              state <= ld_q ? WAIT : DONE;
            end else begin
              err_q <= 1'b1;
              state <= DONE;
            end
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (i_dmem_rvalid) begin
            cap   <= i_dmem_rdata;
            state <= DONE;
          end else if (cnt >= CW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ld_b = cap[{a_q, 3'b000} +: 8];
  assign ld_h = cap[{a_q[1], 4'b0000} +: 16];

  always_comb begin
    read_data_M = 32'd0;
    if ((state == DONE) && ld_q && !err_q) begin
      case (op_q)
        3'b000:  read_data_M = {{24{ld_b[7]}}, ld_b};
        3'b100:  read_data_M = {24'd0, ld_b};
        3'b001:  read_data_M = {{16{ld_h[15]}}, ld_h};
        3'b101:  read_data_M = {16'd0, ld_h};
        default: read_data_M = cap;
      endcase
    end
  end

  assign stall_M = !i_rst && (((state == IDLE) && acc && !bad) || (state == REQ) || (state == WAIT));
  assign err_M   = !i_rst && (((state == IDLE) && acc && bad) || ((state == DONE) && err_q));

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu with a byte-level memory model
// A responder plays the data memory; a monitor checks requests and completions against queued expectations.
module tb_mem_stage_lsu;

  localparam int TO = 16;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] alu_data_M = '0, store_data_M = '0;
  logic [2:0]  lsu_op_M = '0;
  logic        mem_rd_M = 1'b0, mem_wr_M = 1'b0;
  logic [31:0] read_data_M;
  logic        stall_M, err_M;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ready = 1'b0, i_dmem_rvalid = 1'b0;
  logic [31:0] i_dmem_rdata = '0;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .alu_data_M(alu_data_M), .store_data_M(store_data_M), .lsu_op_M(lsu_op_M),
    .mem_rd_M(mem_rd_M), .mem_wr_M(mem_wr_M),
    .read_data_M(read_data_M), .stall_M(stall_M), .err_M(err_M),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
    .i_dmem_ready(i_dmem_ready), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;

  resp_t exp_q[$];
  req_t  req_q[$];

  int checks = 0;
  int errors = 0;

  // Window 0x100..0x13F: responder stores words, reference model stores bytes.
  logic [31:0] mem_words [0:15];
  logic [7:0]  model_bytes [0:63];

  int mode = 0, rdy_delay = 0, rv_delay = 0;
  int rdy_cnt = 0, rd_cnt = 0;
  bit rd_pending = 0;
  logic [31:0] rd_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic predict(input bit rd, input bit wr, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input int md, input int rdy, input int rv,
                         input bit push_resp, output int exp_stall);
    int size, off;
    bit legal, bad;
    req_t r;
    resp_t e;
    logic [31:0] v, dw;
    size  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    legal = op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    off   = int'(addr[5:0]);
    bad   = !legal || (rd && wr) || ((addr % size) != 0);
    e.rdata = 32'd0;
    e.err   = 1'b1;
    exp_stall = 0;
    dw = data;
    if (!bad) begin
      if (md == 1) begin
        exp_stall = 1 + TO;
      end else begin
        r.addr = {addr[31:2], 2'b00};
        r.we = wr;
        r.be = 4'b0000;
        r.wdata = 32'd0;
        if (wr) begin
          for (int k = 0; k < size; k++) r.be[int'(addr[1:0]) + k] = 1'b1;
          for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = dw[8*(i % size) +: 8];
        end
        req_q.push_back(r);
        if (wr) begin
          for (int k = 0; k < size; k++) model_bytes[off + k] = dw[8*k +: 8];
          e.err = 1'b0;
          exp_stall = 2 + rdy;
        end else if (md == 2) begin
          exp_stall = 1 + TO;
        end else begin
          v = 32'd0;
          for (int k = 0; k < size; k++) v = v | (32'(model_bytes[off + k]) << (8 * k));
          if (!op[2] && size < 4 && v[8*size-1]) v = v | (~32'd0 << (8 * size));
          e.rdata = v;
          e.err = 1'b0;
          exp_stall = 3 + rdy + rv;
        end
      end
    end
    if (push_resp) exp_q.push_back(e);
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input int md, input int rdy, input int rv);
    mode = md; rdy_delay = rdy; rv_delay = rv;
    mem_rd_M = rd; mem_wr_M = wr; lsu_op_M = op; alu_data_M = addr; store_data_M = data;
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input int md, input int rdy, input int rv);
    int es, sc;
    bit done;
    @(negedge i_clk);
    predict(rd, wr, op, addr, data, md, rdy, rv, 1'b1, es);
    drive(rd, wr, op, addr, data, md, rdy, rv);
    sc = 0;
    done = 0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (!stall_M) begin
        done = 1;
        break;
      end
      sc++;
      @(negedge i_clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout: stall_M still %b after 40 cycles, expected 0", stall_M);
    end else begin
      check("stall_cycles", 32'(sc), 32'(es));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      mem_rd_M = 1'b0;
      mem_wr_M = 1'b0;
    end
  endtask

  // Data-memory responder: ready after rdy_delay cycles of req, rvalid rv_delay cycles after acceptance.
  initial begin
    int idx;
    forever begin
      @(negedge i_clk);
      i_dmem_ready = 1'b0;
      i_dmem_rvalid = 1'b0;
      i_dmem_rdata = 32'd0;
      if (i_rst) begin
        rd_pending = 0;
        rdy_cnt = 0;
      end else if (rd_pending) begin
        if (rd_cnt == 0) begin
          i_dmem_rvalid = 1'b1;
          i_dmem_rdata = rd_word;
          rd_pending = 0;
        end else begin
          rd_cnt--;
        end
      end else if (o_dmem_req && mode != 1) begin
        if (rdy_cnt < rdy_delay) begin
          rdy_cnt++;
        end else begin
          i_dmem_ready = 1'b1;
          rdy_cnt = 0;
          idx = int'(o_dmem_addr[5:2]);
          if (o_dmem_we) begin
            for (int b = 0; b < 4; b++)
              if (o_dmem_be[b]) mem_words[idx][8*b +: 8] = o_dmem_wdata[8*b +: 8];
          end else if (mode == 0) begin
            rd_pending = 1;
            rd_cnt = rv_delay;
            rd_word = mem_words[idx];
          end
        end
      end
    end
  end

  // Monitor: accepted requests and instruction completions are matched against the queues.
  initial begin
    req_t r, prev;
    resp_t e;
    bit prev_wait;
    prev_wait = 0;
    forever begin
      @(negedge i_clk);
      #1;
      if (i_rst) begin
        prev_wait = 0;
        continue;
      end
      if (o_dmem_req && prev_wait) begin
        check("req_hold_addr", o_dmem_addr, prev.addr);
        check("req_hold_be", 32'(o_dmem_be), 32'(prev.be));
        check("req_hold_wdata", o_dmem_wdata, prev.wdata);
        check("req_hold_we", 32'(o_dmem_we), 32'(prev.we));
      end
      if (o_dmem_req && i_dmem_ready) begin
        prev_wait = 0;
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %h we %b, expected no request", o_dmem_addr, o_dmem_we);
        end else begin
          r = req_q.pop_front();
          check("req_addr", o_dmem_addr, r.addr);
          check("req_we", 32'(o_dmem_we), 32'(r.we));
          check("req_be", 32'(o_dmem_be), 32'(r.be));
          check("req_wdata", o_dmem_wdata, r.wdata);
        end
      end else if (o_dmem_req) begin
        prev_wait = 1;
        prev.addr = o_dmem_addr; prev.we = o_dmem_we; prev.be = o_dmem_be; prev.wdata = o_dmem_wdata;
      end else begin
        prev_wait = 0;
      end
      if ((mem_rd_M || mem_wr_M) && !stall_M) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got read_data %h err %b, expected none", read_data_M, err_M);
        end else begin
          e = exp_q.pop_front();
          check("read_data_M", read_data_M, e.rdata);
          check("err_M", 32'(err_M), 32'(e.err));
        end
      end
    end
  end

  initial begin
    logic [31:0] w;
    int es;
    int rd, wr, md, ro;
    logic [2:0] op;
    for (int i = 0; i < 16; i++) begin
      w = (32'h1357_9BDF * 32'(i + 1)) ^ 32'hA5A5_0F0F;
      mem_words[i] = w;
      for (int b = 0; b < 4; b++) model_bytes[4*i + b] = w[8*b +: 8];
    end

    #1;
    check("rst_req", 32'(o_dmem_req), 32'd0);
    check("rst_stall", 32'(stall_M), 32'd0);
    check("rst_err", 32'(err_M), 32'd0);
    check("rst_read_data", read_data_M, 32'd0);
    check("rst_addr", o_dmem_addr, 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    idle(2);

    issue(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 0);
    issue(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 1);
    issue(0, 1, 3'b010, 32'h100, 32'h80FF_1234, 0, 1, 0);
    issue(1, 0, 3'b000, 32'h103, 32'h0, 0, 0, 0);
    issue(1, 0, 3'b100, 32'h103, 32'h0, 0, 2, 2);
    issue(0, 1, 3'b010, 32'h100, 32'h8001_0000, 0, 0, 0);
    issue(1, 0, 3'b001, 32'h102, 32'h0, 0, 0, 0);
    issue(0, 1, 3'b001, 32'h102, 32'h0000_ABCD, 0, 3, 0);
    issue(1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 0);
    issue(1, 0, 3'b010, 32'h104, 32'h0, 1, 0, 0);
    issue(1, 0, 3'b010, 32'h108, 32'h0, 2, 1, 0);
    idle(1);

    // Reset pulsed while the load sits in WAIT.
    @(negedge i_clk);
    predict(1, 0, 3'b010, 32'h104, 32'h0, 0, 0, 4, 1'b0, es);
    drive(1, 0, 3'b010, 32'h104, 32'h0, 0, 0, 4);
    @(negedge i_clk);
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("wait_rst_req", 32'(o_dmem_req), 32'd0);
    check("wait_rst_stall", 32'(stall_M), 32'd0);
    check("wait_rst_err", 32'(err_M), 32'd0);
    check("wait_rst_read_data", read_data_M, 32'd0);
    check("wait_rst_be", 32'(o_dmem_be), 32'd0);
    mem_rd_M = 1'b0;
    @(negedge i_clk);
    #2 i_rst = 1'b0;
    #1;
    check("post_rst_stall", 32'(stall_M), 32'd0);
    check("post_rst_req", 32'(o_dmem_req), 32'd0);
    idle(1);

    for (int t = 0; t < 250; t++) begin
      wr = ($urandom_range(0, 2) == 0) ? 1 : 0;
      rd = wr ? 0 : 1;
      if ($urandom_range(0, 19) == 0) begin rd = 1; wr = 1; end
      op = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      ro = $urandom_range(0, 19);
      md = (ro == 0) ? 1 : (ro == 1 && !wr) ? 2 : 0;
      issue(rd[0], wr[0], op, 32'h100 + 32'($urandom_range(0, 63)), $urandom(),
            md, $urandom_range(0, 4), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
